// File: rtl/mul_seq_ctrl.sv
// Iterative radix-2 shift-add multiplier sequencer for the execute stage.
// Holds the pipeline through stall while it produces the low XLEN bits of src_a*src_b.
module mul_seq_ctrl #(
   parameter int XLEN       = 32,
   parameter bit EARLY_EXIT = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [3:0]      alucontrol,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam logic [3:0] ALU_MUL = 4'b1111;
   localparam int         CW      = $clog2(XLEN + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [XLEN-1:0] mcand, mplier, acc;
   logic [XLEN-1:0] mcand_nxt, mplier_nxt, acc_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            request, accept, finish;

   assign request = start && (alucontrol == ALU_MUL);

   // One shift-add step; carries out of bit XLEN-1 are dropped since only the low word is kept.
   always_comb begin
      acc_nxt    = mplier[0] ? (acc + mcand) : acc;
      mcand_nxt  = mcand << 1;
      mplier_nxt = mplier >> 1;
      cnt_nxt    = cnt - CW'(1);
      finish     = (cnt_nxt == '0) || (EARLY_EXIT && (mplier_nxt == '0));
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      stall     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (request && !flush) begin
               accept    = 1'b1;
               stall     = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            busy  = 1'b1;
            stall = 1'b1;
            if (flush) begin
               state_nxt = IDLE;
            end else if (finish) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = !flush;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A flush during BUSY freezes the datapath; result only moves on a completed multiply.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         result <= '0;
      end else if (accept) begin
         mcand  <= src_a;
         mplier <= src_b;
         acc    <= '0;
         cnt    <= CW'(XLEN);
      end else if ((state == BUSY) && !flush) begin
         mcand  <= mcand_nxt;
         mplier <= mplier_nxt;
         acc    <= acc_nxt;
         cnt    <= cnt_nxt;
         if (finish) begin
            result <= acc_nxt;
         end
      end
   end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: one instance with fixed iterations, one with early exit.
// Stimulus pushes expected {result, done cycle}; a negedge monitor pops on every done pulse.
module tb_mul_seq_ctrl;

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start0, flush0, stall0, busy0, done0;
   logic [3:0]  alu0;
   logic [31:0] a0, b0, res0;
   logic        start1, flush1, stall1, busy1, done1;
   logic [3:0]  alu1;
   logic [31:0] a1, b1, res1;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;
   int   cyc = 0;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mul_seq_ctrl #(.XLEN(32), .EARLY_EXIT(1'b0)) dut_fix (
      .clk(clk), .rst_n(rst_n), .start(start0), .alucontrol(alu0), .src_a(a0), .src_b(b0),
      .flush(flush0), .stall(stall0), .busy(busy0), .done(done0), .result(res0)
   );

   mul_seq_ctrl #(.XLEN(32), .EARLY_EXIT(1'b1)) dut_ee (
      .clk(clk), .rst_n(rst_n), .start(start1), .alucontrol(alu1), .src_a(a1), .src_b(b1),
      .flush(flush1), .stall(stall1), .busy(busy1), .done(done1), .result(res1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done0) begin
         if (q0.size() == 0) check("fix_unexpected_done", 32'(done0), 0);
         else begin
            e0 = q0.pop_front();
            check("fix_result", res0, e0.res);
            check("fix_done_cycle", cyc, e0.cyc);
         end
      end
      if (rst_n && done1) begin
         if (q1.size() == 0) check("ee_unexpected_done", 32'(done1), 0);
         else begin
            e1 = q1.pop_front();
            check("ee_result", res1, e1.res);
            check("ee_done_cycle", cyc, e1.cyc);
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Done is seen at the negedge lat edges after the accepting edge.
   task automatic issue0(input logic [31:0] a, input logic [31:0] b, input bit expect_done,
                         input logic [31:0] exp_res);
      @(negedge clk);
      start0 = 1'b1; alu0 = 4'b1111; a0 = a; b0 = b;
      #1 check("fix_req_stall", 32'(stall0), 1);
      @(posedge clk); #1;
      if (expect_done) q0.push_back('{exp_res, cyc + 32});
      start0 = 1'b0; a0 = ~a; b0 = ~b;
      @(negedge clk);
   endtask

   task automatic issue1(input logic [31:0] a, input logic [31:0] b, input int lat,
                         input logic [31:0] exp_res);
      @(negedge clk);
      start1 = 1'b1; alu1 = 4'b1111; a1 = a; b1 = b;
      #1 check("ee_req_stall", 32'(stall1), 1);
      @(posedge clk); #1;
      q1.push_back('{exp_res, cyc + lat});
      start1 = 1'b0; a1 = ~a; b1 = ~b;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 20000", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  n;
      bit  seen;

      rst_n = 1'b0;
      start0 = 1'b0; alu0 = 4'h0; a0 = '0; b0 = '0; flush0 = 1'b0;
      start1 = 1'b0; alu1 = 4'h0; a1 = '0; b1 = '0; flush1 = 1'b0;
      wait_cycles(2);
      check("reset_stall", 32'(stall0), 0);
      check("reset_busy", 32'(busy0), 0);
      check("reset_done", 32'(done0), 0);
      check("reset_result", res0, 0);
      rst_n = 1'b1;
      wait_cycles(2);

      // 7*6: stall spans the request cycle plus 32 BUSY cycles, then done with stall low.
      @(negedge clk);
      start0 = 1'b1; alu0 = 4'b1111; a0 = 32'd7; b0 = 32'd6;
      #1;
      n = 0; seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (done0) begin
            seen = 1'b1;
            check("t1_stall_in_done", 32'(stall0), 0);
            break;
         end
         if (stall0) n++;
         if (i == 5) check("t1_busy", 32'(busy0), 1);
         if (i == 0) begin
            @(posedge clk); #1;
            q0.push_back('{32'd42, cyc + 32});
            start0 = 1'b0; a0 = 32'hdead_beef; b0 = 32'h1234_5678;
         end
         @(negedge clk); #1;
      end
      check("t1_done_seen", 32'(seen), 1);
      check("t1_stall_cycles", n, 33);
      @(negedge clk); #1;
      check("t1_done_one_cycle", 32'(done0), 0);

      // Wrap-around products.
      issue0(32'hffff_ffff, 32'hffff_ffff, 1'b1, 32'h0000_0001);
      wait_cycles(36);
      issue0(32'h8000_0000, 32'd2, 1'b1, 32'h0000_0000);
      wait_cycles(36);

      // Back-to-back: start held through BUSY; second operands appear in the done cycle.
      @(negedge clk);
      start0 = 1'b1; alu0 = 4'b1111; a0 = 32'd2; b0 = 32'd3;
      @(posedge clk); #1;
      q0.push_back('{32'd6, cyc + 32});
      for (int i = 0; i < 50; i++) begin
         @(negedge clk); #1;
         if (done0) break;
      end
      check("t5_first_done", 32'(done0), 1);
      check("t5_done_no_stall", 32'(stall0), 0);
      a0 = 32'd4; b0 = 32'd5;
      @(posedge clk); #1;
      check("t5_idle_req_stall", 32'(stall0), 1);
      @(posedge clk); #1;
      q0.push_back('{32'd20, cyc + 32});
      check("t5_second_busy", 32'(busy0), 1);
      start0 = 1'b0;
      wait_cycles(36);

      // Flush 10 cycles into BUSY: back to IDLE, no done, result keeps 20.
      issue0(32'd7, 32'd9, 1'b0, 32'd0);
      wait_cycles(9);
      flush0 = 1'b1;
      @(posedge clk); #1;
      flush0 = 1'b0;
      check("t3_flush_busy", 32'(busy0), 0);
      check("t3_flush_stall", 32'(stall0), 0);
      check("t3_flush_done", 32'(done0), 0);
      check("t3_flush_result", res0, 32'd20);
      @(negedge clk);
      flush0 = 1'b1; start0 = 1'b1; alu0 = 4'b1111; a0 = 32'd3; b0 = 32'd3;
      @(posedge clk); #1;
      flush0 = 1'b0; start0 = 1'b0;
      check("t3_flush_drops_req", 32'(busy0), 0);
      wait_cycles(40);

      // Non-MUL alucontrol never stalls.
      @(negedge clk);
      start0 = 1'b1; alu0 = 4'b0010; a0 = 32'd7; b0 = 32'd6;
      for (int i = 0; i < 4; i++) begin
         #1 check("t6_nonmul_stall", 32'(stall0), 0);
         @(negedge clk);
      end
      check("t6_nonmul_busy", 32'(busy0), 0);
      start0 = 1'b0;

      // Early exit: lat = index of highest set bit of src_b plus 1, minimum 1.
      issue1(32'd12, 32'd5, 3, 32'd60);
      wait_cycles(6);
      issue1(32'd7, 32'd0, 1, 32'd0);
      wait_cycles(4);
      issue1(32'd6, 32'd7, 3, 32'd42);
      wait_cycles(6);
      issue1(32'hffff_ffff, 32'hffff_ffff, 32, 32'h0000_0001);
      wait_cycles(36);

      // Async reset mid-BUSY clears everything at once; then a fresh 3*5.
      issue0(32'd9, 32'd9, 1'b0, 32'd0);
      wait_cycles(5);
      rst_n = 1'b0;
      #1;
      check("t4_rst_stall", 32'(stall0), 0);
      check("t4_rst_busy", 32'(busy0), 0);
      check("t4_rst_done", 32'(done0), 0);
      check("t4_rst_result", res0, 0);
      check("t4_rst_result_ee", res1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      issue0(32'd3, 32'd5, 1'b1, 32'd15);
      wait_cycles(36);

      check("q_fix_drained", q0.size(), 0);
      check("q_ee_drained", q1.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
